// File: rtl/pipe_mem_sched.sv
// Pipeline sequencer for a 5-stage core whose IF and MEM stages share one memory port.
// Data accesses win the port first; the pipeline advances once per completed fetch.
module pipe_mem_sched #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_hazy_i,
    input  logic             pc_src_id_i,
    input  logic             dmem_req_im_i,
    input  logic             dmem_we_im_i,
    input  logic             port_ready_i,
    output logic             port_valid_o,
    output logic             port_sel_o,
    output logic             port_we_o,
    output logic             en_if_o,
    output logic             en_id_o,
    output logic             clr_id_o,
    output logic             en_ie_o,
    output logic             clr_ie_o,
    output logic             en_im_o,
    output logic             en_iwb_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {
        S_DATA  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_q;

    logic valid;
    logic sel;
    logic adv;
    logic waiting;

    // Port arbitration: a pending data access is served before the slot's fetch.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        sel     = 1'b0;
        adv     = 1'b0;
        if (run_q) begin
            valid = 1'b1;
            unique case (state_q)
                S_DATA: begin
                    if (dmem_req_im_i) begin
                        sel = 1'b1;
                        if (port_ready_i) begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        adv = port_ready_i;
                    end
                end
                S_FETCH: begin
                    if (port_ready_i) begin
                        adv     = 1'b1;
                        state_d = S_DATA;
                    end
                end
                default: state_d = S_DATA;
            endcase
        end
    end

    // Stage strobes: a hazard bubbles ID/IE and overrides any branch squash.
    always_comb begin
        en_if_o  = 1'b0;
        en_id_o  = 1'b0;
        clr_id_o = 1'b0;
        en_ie_o  = 1'b0;
        clr_ie_o = 1'b0;
        en_im_o  = 1'b0;
        en_iwb_o = 1'b0;
        if (adv) begin
            en_ie_o  = 1'b1;
            en_im_o  = 1'b1;
            en_iwb_o = 1'b1;
            if (is_hazy_i) begin
                clr_ie_o = 1'b1;
            end else begin
                en_if_o  = 1'b1;
                en_id_o  = 1'b1;
                clr_id_o = pc_src_id_i;
            end
        end
    end

    assign waiting      = valid & ~port_ready_i;
    assign port_valid_o = valid;
    assign port_sel_o   = sel;
    assign port_we_o    = valid & sel & dmem_we_im_i;
    assign timeout_o    = run_q & timeout_q;
    assign stall_cnt_o  = run_q ? stall_q : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DATA;
            run_q     <= 1'b0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;

            // wait_q parks at its last value; the timeout flag is sticky.
            if (waiting) begin
                if (wait_q == WAIT_LAST) begin
                    timeout_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end else begin
                wait_q <= '0;
            end

            if (run_q && !en_if_o && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_sched.sv
// Self-checking bench for pipe_mem_sched: directed scenarios plus randomized traffic,
// compared every cycle against a slot-level behavioural model.
module tb_pipe_mem_sched;

    localparam int MAX_WAIT  = 8;
    localparam int CNT_W     = 8;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             is_hazy, pc_src, dmem_req, dmem_we, port_ready;
    logic             port_valid, port_sel, port_we;
    logic             en_if, en_id, clr_id, en_ie, clr_ie, en_im, en_iwb, timeout;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_mem_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .is_hazy_i     (is_hazy),
        .pc_src_id_i   (pc_src),
        .dmem_req_im_i (dmem_req),
        .dmem_we_im_i  (dmem_we),
        .port_ready_i  (port_ready),
        .port_valid_o  (port_valid),
        .port_sel_o    (port_sel),
        .port_we_o     (port_we),
        .en_if_o       (en_if),
        .en_id_o       (en_id),
        .clr_id_o      (clr_id),
        .en_ie_o       (en_ie),
        .clr_ie_o      (clr_ie),
        .en_im_o       (en_im),
        .en_iwb_o      (en_iwb),
        .timeout_o     (timeout),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: running flag, "this slot's data access already done", consecutive wait count,
    // sticky timeout and stall total.
    bit m_run, m_data_done, m_to, slot_start;
    int m_wait, m_stall;

    bit e_valid, e_sel, e_we, e_en_if, e_en_id, e_clr_id, e_en_ie, e_clr_ie, e_en_im, e_en_iwb;
    bit e_data_ph, e_adv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_data_done = 0; m_to = 0; m_wait = 0; m_stall = 0; slot_start = 1;
    endtask

    task automatic predict_and_check();
        {e_valid, e_sel, e_we, e_en_if, e_en_id, e_clr_id, e_en_ie, e_clr_ie, e_en_im, e_en_iwb} = '0;
        e_data_ph = 0;
        e_adv     = 0;
        if (m_run) begin
            e_data_ph = dmem_req && !m_data_done;
            e_valid   = 1;
            e_sel     = e_data_ph;
            e_we      = e_data_ph && dmem_we;
            e_adv     = !e_data_ph && port_ready;
            if (e_adv) begin
                e_en_ie = 1; e_en_im = 1; e_en_iwb = 1;
                if (is_hazy) e_clr_ie = 1;
                else begin
                    e_en_if = 1; e_en_id = 1; e_clr_id = pc_src;
                end
            end
        end
        check("valid",   32'(port_valid), 32'(e_valid));
        check("sel",     32'(port_sel),   32'(e_sel));
        check("we",      32'(port_we),    32'(e_we));
        check("en_if",   32'(en_if),      32'(e_en_if));
        check("en_id",   32'(en_id),      32'(e_en_id));
        check("clr_id",  32'(clr_id),     32'(e_clr_id));
        check("en_ie",   32'(en_ie),      32'(e_en_ie));
        check("clr_ie",  32'(clr_ie),     32'(e_clr_ie));
        check("en_im",   32'(en_im),      32'(e_en_im));
        check("en_iwb",  32'(en_iwb),     32'(e_en_iwb));
        check("timeout", 32'(timeout),    32'(m_run && m_to));
        check("stall",   32'(stall_cnt),  m_run ? 32'(m_stall) : 32'd0);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            m_run      = 1;
            slot_start = 1;
        end else begin
            if (!port_ready) begin
                m_wait++;
                if (m_wait >= MAX_WAIT) m_to = 1;
            end else begin
                m_wait = 0;
            end
            if (!e_en_if && m_stall < STALL_MAX) m_stall++;
            if (e_data_ph && port_ready) m_data_done = 1;
            if (e_adv) m_data_done = 0;
            slot_start = e_adv;
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit req, input bit we, input bit rdy, input bit hz, input bit pc);
        dmem_req   = req;
        dmem_we    = we;
        port_ready = rdy;
        is_hazy    = hz;
        pc_src     = pc;
        @(negedge clk);
        predict_and_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic random_cycles(input int n);
        bit req, we;
        req = dmem_req;
        we  = dmem_we;
        for (int i = 0; i < n; i++) begin
            if (slot_start) begin
                req = 1'($urandom_range(0, 1));
                we  = 1'($urandom_range(0, 1));
            end
            cycle(req, we, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        {dmem_req, dmem_we, port_ready, is_hazy, pc_src} = '0;

        // Reset held: everything zero.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        rst_n = 1'b1;

        // T1: one idle cycle, then a fetch-only slot every cycle.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);

        // T2: store then fetch, two slots.
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);

        // T3: fetch held off for 3 cycles, completes on the 4th.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // T4: hazard beats branch, then a plain branch squash.
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);

        // Wait of MAX_WAIT-1 cycles must not trip the timeout.
        for (int i = 0; i < MAX_WAIT - 1; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        random_cycles(300);

        // Stall counter driven to saturation with a long hazard run.
        if (!slot_start) begin
            for (int i = 0; i < 4; i++) cycle(dmem_req, dmem_we, 1, 0, 0);
        end
        for (int i = 0; i < STALL_MAX + 5; i++) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);

        // T5: exactly MAX_WAIT waits sets the timeout, which stays after ready returns.
        for (int i = 0; i < MAX_WAIT; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

        // T6: reset asserted in the middle of a data wait.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid_async", 32'(port_valid), 32'd0);
        check("rst_sel_async",   32'(port_sel),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);

        random_cycles(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
